demux1ne8_regshkrim: RTL and testbench

- Write-side counterpart of the 8:1 read mux.
- Takes one write request (3-bit register address plus data) and routes it 1-to-8 into an 8-entry register bank via a registered decode stage.
- Exposes all eight registers in parallel, so the existing 8:1 mux can read them.
- Sits between the CPU write-back stage and the register-read muxes.

---
 rtl/demux1ne8_regshkrim_pkg.sv | 23 ++
 rtl/demux1ne8_regshkrim_if.sv | 28 ++
 rtl/demux1ne8_regshkrim_dekoder3ne8.sv | 15 +
 rtl/demux1ne8_regshkrim.sv | 114 +++++++++++
 tb/tb_demux1ne8_regshkrim.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/demux1ne8_regshkrim_pkg.sv
// Shared CPU register-file constants.
// Imported by the write demux, its decoder and the control unit.
package demux1ne8_regshkrim_pkg;

  localparam int REG_COUNT = 8;
  localparam int REG_ADR_W = 3;
  localparam int DATA_W    = 16;
  localparam int R0_IDX    = 0;

  typedef logic [REG_ADR_W-1:0] reg_adr_t;
  typedef logic [REG_COUNT-1:0] reg_sel_t;

  function automatic reg_sel_t onehot8(
    input logic     en,
    input reg_adr_t adr
  );
    reg_sel_t s;
    s = '0;
    if (en) s[adr] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/demux1ne8_regshkrim_if.sv
// Write-request bundle from write-back into the register bank.
// Master drives a request; slave (the bank) consumes it.
interface demux1ne8_regshkrim_if
  import demux1ne8_regshkrim_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic             w_en;
  reg_adr_t         w_adr;
  logic [WIDTH-1:0] w_data;
  logic             pastro;

  modport master (
    output w_en,
    output w_adr,
    output w_data,
    output pastro
  );

  modport slave (
    input w_en,
    input w_adr,
    input w_data,
    input pastro
  );

endinterface

// File: rtl/demux1ne8_regshkrim_dekoder3ne8.sv
// 3-to-8 one-hot decoder with enable.
// Output is all-zero when disabled.
module dekoder3ne8
  import demux1ne8_regshkrim_pkg::*;
(
  input  logic     en,
  input  reg_adr_t adr,
  output reg_sel_t y
);

  always_comb begin
    y = onehot8(en, adr);
  end

endmodule

// File: rtl/demux1ne8_regshkrim.sv
// 1-to-8 write demux into an 8-entry register bank.
// Stage 1 decodes and latches the request, stage 2 commits it.
module demux1ne8_regshkrim
  import demux1ne8_regshkrim_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter bit R0_ZERO = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  demux1ne8_regshkrim_if.slave  wr,
  output logic [WIDTH-1:0]      dalja0,
  output logic [WIDTH-1:0]      dalja1,
  output logic [WIDTH-1:0]      dalja2,
  output logic [WIDTH-1:0]      dalja3,
  output logic [WIDTH-1:0]      dalja4,
  output logic [WIDTH-1:0]      dalja5,
  output logic [WIDTH-1:0]      dalja6,
  output logic [WIDTH-1:0]      dalja7,
  output reg_sel_t              zgjedhja,
  output logic                  ne_pritje,
  output reg_sel_t              vlefshem
);

  reg_sel_t         dec;
  reg_sel_t         sel_q, sel_d;
  logic             pend_q, pend_d;
  reg_adr_t         adr_q, adr_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [WIDTH-1:0] bank_q [REG_COUNT];
  logic [WIDTH-1:0] bank_d [REG_COUNT];
  reg_sel_t         vld_q, vld_d;
  logic             r0_blk;

  dekoder3ne8 u_dek (
    .en  (wr.w_en),
    .adr (wr.w_adr),
    .y   (dec)
  );

  always_comb begin
    sel_d  = dec;
    pend_d = wr.w_en;
    adr_d  = adr_q;
    data_d = data_q;
    if (wr.w_en) begin
      adr_d  = wr.w_adr;
      data_d = wr.w_data;
    end
    if (wr.pastro) begin
      sel_d  = '0;
      pend_d = 1'b0;
    end
  end

  assign r0_blk = R0_ZERO && (adr_q == REG_ADR_W'(R0_IDX));

  // Commit drives off the stage-1 contents; clear drops it outright.
  always_comb begin
    for (int k = 0; k < REG_COUNT; k++) begin
      bank_d[k] = bank_q[k];
    end
    vld_d = vld_q;
    if (wr.pastro) begin
      for (int k = 0; k < REG_COUNT; k++) begin
        bank_d[k] = '0;
      end
      vld_d = '0;
    end else if (pend_q && !r0_blk) begin
      for (int k = 0; k < REG_COUNT; k++) begin
        if (sel_q[k]) begin
          bank_d[k] = data_q;
          vld_d[k]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= '0;
      pend_q <= 1'b0;
      adr_q  <= '0;
      data_q <= '0;
      vld_q  <= '0;
      for (int k = 0; k < REG_COUNT; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      sel_q  <= sel_d;
      pend_q <= pend_d;
      adr_q  <= adr_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      for (int k = 0; k < REG_COUNT; k++) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  assign dalja0    = bank_q[0];
  assign dalja1    = bank_q[1];
  assign dalja2    = bank_q[2];
  assign dalja3    = bank_q[3];
  assign dalja4    = bank_q[4];
  assign dalja5    = bank_q[5];
  assign dalja6    = bank_q[6];
  assign dalja7    = bank_q[7];
  assign zgjedhja  = sel_q;
  assign ne_pritje = pend_q;
  assign vlefshem  = vld_q;

endmodule

// File: tb/tb_demux1ne8_regshkrim.sv
// Directed bench for the register-bank write demux.
// Two instances share one request bus: R0_ZERO=1 and R0_ZERO=0.
module tb_demux1ne8_regshkrim;
  import demux1ne8_regshkrim_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux1ne8_regshkrim_if #(.WIDTH(16)) wr ();

  logic [15:0] d1 [8];
  logic [15:0] d0 [8];
  logic [7:0]  sel1, vld1, sel0, vld0;
  logic        pend1, pend0;

  demux1ne8_regshkrim #(.WIDTH(16), .R0_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr(wr),
    .dalja0(d1[0]), .dalja1(d1[1]), .dalja2(d1[2]), .dalja3(d1[3]),
    .dalja4(d1[4]), .dalja5(d1[5]), .dalja6(d1[6]), .dalja7(d1[7]),
    .zgjedhja(sel1), .ne_pritje(pend1), .vlefshem(vld1)
  );

  demux1ne8_regshkrim #(.WIDTH(16), .R0_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr(wr),
    .dalja0(d0[0]), .dalja1(d0[1]), .dalja2(d0[2]), .dalja3(d0[3]),
    .dalja4(d0[4]), .dalja5(d0[5]), .dalja6(d0[6]), .dalja7(d0[7]),
    .zgjedhja(sel0), .ne_pritje(pend0), .vlefshem(vld0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] adr,
                       input logic [15:0] data);
    wr.w_en   = en;
    wr.w_adr  = adr;
    wr.w_data = data;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("onehot0_r1", 32'($onehot0(sel1)), 32'd1);
      chk("onehot0_r0", 32'($onehot0(sel0)), 32'd1);
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    wr.pastro = 1'b0;
    drive(1'b1, 3'd3, 16'hBEEF);
    step();
    step();
    for (int k = 0; k < 8; k++) chk($sformatf("rst_d%0d", k), 32'(d1[k]), 0);
    chk("rst_vld", 32'(vld1), 0);
    chk("rst_pend", 32'(pend1), 0);
    chk("rst_sel", 32'(sel1), 0);

    rst_n = 1'b1;
    drive(1'b0, 3'd7, 16'hDEAD);
    step();
    chk("idle_d7", 32'(d1[7]), 0);

    drive(1'b1, 3'd5, 16'h1234);
    step();
    chk("single_sel", 32'(sel1), 32'h20);
    chk("single_pend", 32'(pend1), 1);
    chk("single_d5_early", 32'(d1[5]), 0);
    drive(1'b0, 3'd0, 16'h0000);
    step();
    chk("single_d5", 32'(d1[5]), 32'h1234);
    chk("single_vld", 32'(vld1), 32'h20);
    chk("single_d4", 32'(d1[4]), 0);
    chk("single_pend_off", 32'(pend1), 0);

    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 3'(k), 16'(k * 17));
      step();
      chk($sformatf("strm_sel%0d", k), 32'(sel1), 32'(1 << k));
    end
    drive(1'b0, 3'd0, 16'hFFFF);
    step();
    for (int k = 1; k < 8; k++)
      chk($sformatf("strm_d%0d", k), 32'(d1[k]), 32'(k * 17));
    chk("strm_vld", 32'(vld1), 32'hFE);

    drive(1'b1, 3'd2, 16'hAAAA);
    step();
    drive(1'b1, 3'd2, 16'h5555);
    step();
    chk("pair_first", 32'(d1[2]), 32'hAAAA);
    drive(1'b0, 3'd0, 16'h0000);
    step();
    chk("pair_final", 32'(d1[2]), 32'h5555);

    drive(1'b1, 3'd0, 16'hFFFF);
    step();
    drive(1'b0, 3'd0, 16'h0000);
    step();
    chk("r0z_d0", 32'(d1[0]), 0);
    chk("r0z_vld0", 32'(vld1[0]), 0);
    chk("r0w_d0", 32'(d0[0]), 32'hFFFF);
    chk("r0w_vld0", 32'(vld0[0]), 1);

    for (int mode = 0; mode < 2; mode++) begin
      drive(1'b1, 3'd6, 16'h1111);
      step();
      drive(1'b0, 3'd0, 16'h0000);
      step();
      chk($sformatf("race%0d_pre_d6", mode), 32'(d1[6]), 32'h1111);
      drive(1'b1, 3'd4, 16'h7777);
      step();
      drive(1'b1, 3'd6, 16'h9999);
      if (mode == 0) wr.pastro = 1'b1;
      else rst_n = 1'b0;
      step();
      wr.pastro = 1'b0;
      rst_n     = 1'b1;
      drive(1'b0, 3'd0, 16'h0000);
      chk($sformatf("race%0d_d4", mode), 32'(d1[4]), 0);
      chk($sformatf("race%0d_d6", mode), 32'(d1[6]), 0);
      chk($sformatf("race%0d_vld", mode), 32'(vld1), 0);
      chk($sformatf("race%0d_pend", mode), 32'(pend1), 0);
      chk($sformatf("race%0d_sel", mode), 32'(sel1), 0);
      step();
      chk($sformatf("race%0d_d4_late", mode), 32'(d1[4]), 0);
      chk($sformatf("race%0d_d6_late", mode), 32'(d1[6]), 0);
      chk($sformatf("race%0d_d2", mode), 32'(d1[2]), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
